// File: rtl/divmod_pkg.sv
// rtl/divmod_pkg.sv - shared state encoding and sizing helper for the sequential divider
package divmod_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Step counter has to hold values up to W.
    function automatic int cnt_width(input int w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/divmod_step.sv
// rtl/divmod_step.sv - one combinational restoring shift-subtract division step
module divmod_step #(
    parameter int W = 8
) (
    input  logic [W:0]   r_in,
    input  logic         a_msb,
    input  logic [W-1:0] d,
    output logic [W:0]   r_out,
    output logic         q_bit
);

    logic [W:0] r_sh;

    assign r_sh = {r_in[W-1:0], a_msb};

    // r_in[W] is always 0 between steps because r < d; folding it in keeps the step total.
    assign q_bit = r_in[W] | (r_sh >= {1'b0, d});
    assign r_out = q_bit ? (r_sh - {1'b0, d}) : r_sh;

endmodule

// File: rtl/divmod_seq.sv
// rtl/divmod_seq.sv - sequential quotient/remainder/divisibility unit (optional EARLY_EXIT_EN)
module divmod_seq
    import divmod_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [W-1:0] dividend,
    input  logic [W-1:0] divisor,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] quotient,
    output logic [W-1:0] remainder,
    output logic         divisible,
    output logic         div_err
);

    localparam int            CW   = cnt_width(W);
    localparam logic [CW-1:0] LAST = CW'(W - 1);

    state_t        state;
    state_t        state_nx;
    logic [W-1:0]  a_q;
    logic [W-1:0]  d_q;
    logic [W-1:0]  q_q;
    logic [W:0]    r_q;
    logic [CW-1:0] cnt_q;
    logic [W:0]    r_nx;
    logic          q_bit;
    logic          short_exit;

    divmod_step #(.W(W)) u_step (
        .r_in  (r_q),
        .a_msb (a_q[W-1]),
        .d     (d_q),
        .r_out (r_nx),
        .q_bit (q_bit)
    );

    // Evaluated only on the first RUN cycle, while a_q still holds the unshifted dividend.
`ifdef EARLY_EXIT_EN
    assign short_exit = (d_q == '0) || (a_q < d_q);
`else
    assign short_exit = (d_q == '0);
`endif

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE: if (start) state_nx = ST_RUN;
            ST_RUN:  if (((cnt_q == '0) && short_exit) || (cnt_q == LAST)) state_nx = ST_DONE;
            ST_DONE: state_nx = ST_IDLE;
            default: state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            a_q       <= '0;
            d_q       <= '0;
            q_q       <= '0;
            r_q       <= '0;
            cnt_q     <= '0;
            quotient  <= '0;
            remainder <= '0;
            divisible <= 1'b0;
            div_err   <= 1'b0;
        end else begin
            state <= state_nx;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        a_q   <= dividend;
                        d_q   <= divisor;
                        q_q   <= '0;
                        r_q   <= '0;
                        cnt_q <= '0;
                    end
                end
                ST_RUN: begin
                    if ((cnt_q == '0) && short_exit) begin
                        remainder <= a_q;
                        if (d_q == '0) begin
                            quotient  <= '1;
                            divisible <= 1'b0;
                            div_err   <= 1'b1;
                        end else begin
                            quotient  <= '0;
                            divisible <= (a_q == '0);
                            div_err   <= 1'b0;
                        end
                    end else begin
                        a_q   <= a_q << 1;
                        r_q   <= r_nx;
                        q_q   <= {q_q[W-2:0], q_bit};
                        cnt_q <= cnt_q + 1'b1;
                        if (cnt_q == LAST) begin
                            quotient  <= {q_q[W-2:0], q_bit};
                            remainder <= r_nx[W-1:0];
                            divisible <= (r_nx[W-1:0] == '0);
                            div_err   <= 1'b0;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign busy = (state != ST_IDLE);
    assign done = (state == ST_DONE);

endmodule

// File: tb/tb_divmod_seq.sv
// tb/tb_divmod_seq.sv - directed and W=4 exhaustive self-checking bench for divmod_seq
module tb_divmod_seq;

`ifdef EARLY_EXIT_EN
    localparam int ELAT8 = 2;
    localparam int ELAT4 = 2;
`else
    localparam int ELAT8 = 9;
    localparam int ELAT4 = 5;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] dividend, divisor, quotient, remainder;
    logic       busy, done, divisible, div_err;

    logic       start4;
    logic [3:0] dividend4, divisor4, quotient4, remainder4;
    logic       busy4, done4, divisible4, div_err4;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    divmod_seq #(.W(8)) dut (
        .clk(clk), .rst(rst), .start(start), .dividend(dividend), .divisor(divisor),
        .busy(busy), .done(done), .quotient(quotient), .remainder(remainder),
        .divisible(divisible), .div_err(div_err)
    );

    divmod_seq #(.W(4)) dut4 (
        .clk(clk), .rst(rst), .start(start4), .dividend(dividend4), .divisor(divisor4),
        .busy(busy4), .done(done4), .quotient(quotient4), .remainder(remainder4),
        .divisible(divisible4), .div_err(div_err4)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // lat = number of posedges from the accepting edge (counted as 1) to first done; 0 = timeout
    task automatic run8(input logic [7:0] dd, input logic [7:0] dv, output int lat);
        @(negedge clk);
        dividend = dd;
        divisor  = dv;
        start    = 1'b1;
        lat      = 0;
        for (int e = 1; e <= 40; e++) begin
            @(posedge clk);
            #1;
            start = 1'b0;
            if (done) begin
                lat = e;
                break;
            end
        end
    endtask

    task automatic op8(input string tag, input logic [7:0] dd, input logic [7:0] dv,
                       input logic [7:0] eq, input logic [7:0] er,
                       input logic ediv, input logic eerr, input int elat);
        int lat;
        run8(dd, dv, lat);
        check_eq({tag, "_lat"}, 32'(lat), 32'(elat));
        check_eq({tag, "_q"}, 32'(quotient), 32'(eq));
        check_eq({tag, "_r"}, 32'(remainder), 32'(er));
        check_eq({tag, "_flags"}, {30'd0, divisible, div_err}, {30'd0, ediv, eerr});
        @(posedge clk);
        #1;
        check_eq({tag, "_after"}, {30'd0, busy, done}, 32'd0);
    endtask

    initial begin
        int lat;
        int seen;
        rst = 1'b1;
        start = 1'b0; dividend = '0; divisor = '0;
        start4 = 1'b0; dividend4 = '0; divisor4 = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check_eq("reset_ctrl", {30'd0, busy, done}, 32'd0);
        check_eq("reset_q", 32'(quotient), 32'd0);
        check_eq("reset_r", 32'(remainder), 32'd0);
        check_eq("reset_flags", {30'd0, divisible, div_err}, 32'd0);

        op8("d12_4",   8'd12,  8'd4,   8'd3,   8'd0,  1'b1, 1'b0, 9);
        op8("d255_16", 8'd255, 8'd16,  8'd15,  8'd15, 1'b0, 1'b0, 9);
        op8("d13_4",   8'd13,  8'd4,   8'd3,   8'd1,  1'b0, 1'b0, 9);
        op8("d77_0",   8'd77,  8'd0,   8'hFF,  8'd77, 1'b0, 1'b1, 2);
        op8("d8_8",    8'd8,   8'd8,   8'd1,   8'd0,  1'b1, 1'b0, 9);
        op8("d255_1",  8'd255, 8'd1,   8'd255, 8'd0,  1'b1, 1'b0, 9);
        op8("d0_5",    8'd0,   8'd5,   8'd0,   8'd0,  1'b1, 1'b0, ELAT8);
        op8("d3_4",    8'd3,   8'd4,   8'd0,   8'd3,  1'b0, 1'b0, ELAT8);
        op8("d7_255",  8'd7,   8'd255, 8'd0,   8'd7,  1'b0, 1'b0, ELAT8);

        // start with 100/7 while 40/5 is running must be ignored
        @(negedge clk);
        dividend = 8'd40; divisor = 8'd5; start = 1'b1;
        lat = 0;
        for (int e = 1; e <= 40; e++) begin
            @(posedge clk);
            #1;
            start = (e == 3);
            if (e == 3) begin
                dividend = 8'd100;
                divisor  = 8'd7;
            end
            if (done) begin
                lat = e;
                break;
            end
        end
        start = 1'b0;
        check_eq("busy_ign_lat", 32'(lat), 32'd9);
        check_eq("busy_ign_q", 32'(quotient), 32'd8);
        check_eq("busy_ign_r", 32'(remainder), 32'd0);
        @(posedge clk);
        #1;
        check_eq("busy_ign_idle", {30'd0, busy, done}, 32'd0);

        // reset during RUN: outputs cleared, no done afterwards
        @(negedge clk);
        dividend = 8'd200; divisor = 8'd3; start = 1'b1;
        for (int e = 1; e <= 4; e++) begin
            @(posedge clk);
            #1;
            start = 1'b0;
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check_eq("rst_mid_ctrl", {30'd0, busy, done}, 32'd0);
        check_eq("rst_mid_q", 32'(quotient), 32'd0);
        check_eq("rst_mid_r", 32'(remainder), 32'd0);
        check_eq("rst_mid_flags", {30'd0, divisible, div_err}, 32'd0);
        seen = 0;
        for (int e = 0; e < 12; e++) begin
            @(posedge clk);
            #1;
            if (done || busy) seen++;
        end
        check_eq("rst_mid_quiet", 32'(seen), 32'd0);
        op8("d9_3", 8'd9, 8'd3, 8'd3, 8'd0, 1'b1, 1'b0, 9);

        // exhaustive W=4 sweep: {lat, q, r, divisible, div_err}
        for (int dd = 0; dd < 16; dd++) begin
            for (int dv = 0; dv < 16; dv++) begin
                logic [3:0] eq4, er4;
                int         el4;
                int         lat4;
                eq4 = (dv == 0) ? 4'hF : 4'(dd / dv);
                er4 = (dv == 0) ? 4'(dd) : 4'(dd % dv);
                el4 = (dv == 0) ? 2 : ((dd < dv) ? ELAT4 : 5);
                @(negedge clk);
                dividend4 = 4'(dd);
                divisor4  = 4'(dv);
                start4    = 1'b1;
                lat4      = 0;
                for (int e = 1; e <= 20; e++) begin
                    @(posedge clk);
                    #1;
                    start4 = 1'b0;
                    if (done4) begin
                        lat4 = e;
                        break;
                    end
                end
                check_eq($sformatf("sweep4_%0d_%0d", dd, dv),
                         {14'd0, 8'(lat4), quotient4, remainder4, divisible4, div_err4},
                         {14'd0, 8'(el4), eq4, er4, (dv != 0) && (er4 == 4'd0), dv == 0});
                @(posedge clk);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
